pdl_arbiter: RTL and testbench
==============================

# pdl_arbiter

Arbiter and sequencer for the 1Kx32 synchronous PDL RAM. Shares the single RAM port between the CPU datapath (fixed-timing, priority requester) and the spy/debug bus (req/ack handshake), so the debug path can read and write the pushdown list while the processor runs. It sits between the datapath, the spy interface and the RAM instance, and drives the RAM's address, data and read/write enables.

## Interface
Parameters:
- ADDR_W, 10, RAM address width (1024 words)
- DATA_W, 32, RAM word width
- STARVE_MAX, 8, spy wait limit in cycles before a forced grant (used only with PDL_ARB_STARVE_EN); range 1..15

Ports:
- clk  in  1  single clock; every register updates on its rising edge
- reset  in  1  synchronous, active-high
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rd  in  1  CPU read request for this cycle
- cpu_wr  in  1  CPU write request for this cycle
- cpu_stall  out  1  CPU access not performed this cycle; CPU holds its request
- cpu_rdata  out  DATA_W  ram_q passthrough
- spy_req  in  1  spy transaction request, level
- spy_we  in  1  1 = write, 0 = read; sampled at grant
- spy_addr  in  ADDR_W  spy address; held until ack
- spy_wdata  in  DATA_W  spy write data; held until ack
- spy_ack  out  1  one-cycle completion pulse
- spy_rdata  out  DATA_W  registered spy read data
- ram_addr  out  ADDR_W  to RAM address
- ram_data  out  DATA_W  to RAM write data
- ram_rden  out  1  to RAM read enable
- ram_wren  out  1  to RAM write enable
- ram_q  in  DATA_W  RAM registered read data

## Operation
- RAM port routing is combinational from the grant decision. Default owner is the CPU: ram_addr = cpu_addr, ram_data = cpu_wdata, ram_wren = cpu_wr, ram_rden = cpu_rd & ~cpu_wr. When cpu_rd and cpu_wr are both high, the write wins and no read is issued.
- FSM states: IDLE, RD_WAIT, ACK.
- **Spy grant.** A grant can occur only in IDLE with spy_req = 1. It happens when the CPU is idle (cpu_rd = cpu_wr = 0), or on a forced grant. In the grant cycle the RAM is driven from spy_addr/spy_wdata, with ram_wren = spy_we and ram_rden = ~spy_we.
- **Spy write.** IDLE -> ACK.
- **Spy read.** IDLE -> RD_WAIT -> ACK. At the end of RD_WAIT, spy_rdata <= ram_q.
- **ACK state.** Asserts spy_ack for one cycle, then returns to IDLE unconditionally.
- **Spy request rules.** spy_req must be deasserted in the cycle after spy_ack. A req still high in that IDLE cycle is treated as a new transaction.
- **CPU access during RD_WAIT and ACK.** CPU accesses proceed normally in these states; the RAM port is free.
- **cpu_rdata validity.** cpu_rdata is valid only in the cycle after an unstalled read. It is undefined in the cycle after a spy read grant.
- spy_rdata holds its value until the next spy read completes.

## Timing
- RAM read latency is 1 cycle.
- CPU read: cpu_rd in cycle N -> data on cpu_rdata in N+1.
- Spy write: grant in G -> write performed at the G edge -> spy_ack in G+1.
- Spy read: grant in G -> ram_q valid in G+1 -> spy_rdata registered at the end of G+1 -> spy_ack in G+2, with spy_rdata valid in the same cycle.
- Best-case spy latency, req to ack: 2 cycles for a write, 3 for a read.
- cpu_stall is combinational. It is 1 only in a forced-grant cycle, or while reset is high.
- Reset values: state IDLE, spy_ack 0, spy_rdata 0, starve count 0. While reset is high, ram_wren = ram_rden = 0 and cpu_stall = 1.
- Reset while in RD_WAIT or ACK aborts the transaction with no ack. The spy side must reissue.

## Configuration
- **Macro:** PDL_ARB_STARVE_EN.
- **Defined.**
  - A 4-bit counter increments each IDLE cycle in which spy_req = 1 and the CPU owns the port.
  - When the count equals STARVE_MAX, the spy is granted in that cycle regardless of CPU requests: cpu_stall = 1 and the CPU request is not issued to the RAM.
  - The counter clears on any spy grant and on reset.
- **Undefined.** There is no counter. cpu_stall is 0 except during reset, and the spy waits indefinitely for a CPU-idle cycle.

## Structure
- Package pdl_arb_pkg:
  - FSM state enum (IDLE, RD_WAIT, ACK)
  - default constants PDL_ADDR_W = 10, PDL_DATA_W = 32, PDL_STARVE_MAX = 8
- Sub-module pdl_starve_counter: counter and compare, producing a force_grant output. It is instantiated only under PDL_ARB_STARVE_EN; otherwise force_grant is tied to 0.

## Test plan
- **CPU only.**
  - Stimulus: cpu_wr addr 0o17 data 0o123456; then cpu_rd addr 0o17.
  - Required response: cpu_rdata = 0o123456 one cycle after the read; spy_ack never asserts.
- **Spy write then read, CPU idle.**
  - Stimulus: spy write addr 0o1777 data 32'hDEADBEEF; then a spy read of the same address.
  - Required response: write ack 2 cycles after req; read ack 3 cycles after req, with spy_rdata = 32'hDEADBEEF.
- **CPU priority (macro off).**
  - Stimulus: CPU reads every cycle for 20 cycles while spy_req = 1.
  - Required response: no grant, cpu_stall = 0 throughout; the spy grant occurs in the first CPU-idle cycle.
- **Starvation (macro on, STARVE_MAX = 8).**
  - Stimulus: CPU busy continuously, spy_req = 1.
  - Required response: the 9th waiting cycle has cpu_stall = 1 and a spy grant; the CPU request is completed on the next cycle.
- **Write-over-read.**
  - Stimulus: cpu_rd = cpu_wr = 1, addr 5.
  - Required response: ram_wren = 1, ram_rden = 0.
- **Reset mid-transaction.**
  - Stimulus: assert reset in RD_WAIT.
  - Required response: no spy_ack; state IDLE; spy_rdata = 0; RAM enables 0 while reset is high.

Source files
------------

// File: rtl/pdl_arb_pkg.sv
// Shared types and default sizing for the PDL RAM arbiter.
package pdl_arb_pkg;

    localparam int PDL_ADDR_W     = 10;
    localparam int PDL_DATA_W     = 32;
    localparam int PDL_STARVE_MAX = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        ACK     = 2'd2
    } arb_state_e;

endpackage

// File: rtl/pdl_arbiter_if.sv
// Spy/debug bus: level request with held address/data, one-cycle ack pulse.
interface pdl_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              spy_req;
    logic              spy_we;
    logic [ADDR_W-1:0] spy_addr;
    logic [DATA_W-1:0] spy_wdata;
    logic              spy_ack;
    logic [DATA_W-1:0] spy_rdata;

    modport master (
        output spy_req, spy_we, spy_addr, spy_wdata,
        input  spy_ack, spy_rdata
    );

    modport slave (
        input  spy_req, spy_we, spy_addr, spy_wdata,
        output spy_ack, spy_rdata
    );
endinterface

// File: rtl/pdl_starve_counter.sv
// Counts IDLE cycles a spy request spends waiting behind the CPU and raises
// force_grant once the wait reaches STARVE_MAX.
module pdl_starve_counter #(
    parameter int STARVE_MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic force_grant
);
    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (inc && cnt_q != 4'hF) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_grant = (cnt_q == 4'(STARVE_MAX));
endmodule

// File: rtl/pdl_arbiter.sv
// Shares the single PDL RAM port between the CPU (priority) and the spy bus.
// Optional spy anti-starvation forced grant: PDL_ARB_STARVE_EN.
module pdl_arbiter
    import pdl_arb_pkg::*;
#(
    parameter int ADDR_W     = PDL_ADDR_W,
    parameter int DATA_W     = PDL_DATA_W,
    parameter int STARVE_MAX = PDL_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    pdl_arbiter_if.slave      spy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_rden,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);
    arb_state_e        state_q, state_d;
    logic [DATA_W-1:0] spy_rdata_q, spy_rdata_d;
    logic              cpu_busy;
    logic              spy_waiting;
    logic              spy_grant;
    logic              force_grant;

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_max_out_of_range
    end

    assign cpu_busy    = cpu_rd | cpu_wr;
    assign spy_waiting = (state_q == IDLE) && spy.spy_req;
    assign spy_grant   = spy_waiting && (!cpu_busy || force_grant) && !reset;

`ifdef PDL_ARB_STARVE_EN
    pdl_starve_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk         (clk),
        .reset       (reset),
        .inc         (spy_waiting && !spy_grant),
        .clr         (spy_grant),
        .force_grant (force_grant)
    );
`else
    assign force_grant = 1'b0;
`endif

    // A forced grant takes the port away from a pending CPU access.
    assign cpu_stall = reset | (spy_grant & force_grant);
    assign cpu_rdata = ram_q;

    always_comb begin
        ram_addr = cpu_addr;
        ram_data = cpu_wdata;
        ram_wren = cpu_wr;
        ram_rden = cpu_rd & ~cpu_wr;
        if (reset) begin
            ram_wren = 1'b0;
            ram_rden = 1'b0;
        end else if (spy_grant) begin
            ram_addr = spy.spy_addr;
            ram_data = spy.spy_wdata;
            ram_wren = spy.spy_we;
            ram_rden = ~spy.spy_we;
        end
    end

    always_comb begin
        state_d     = state_q;
        spy_rdata_d = spy_rdata_q;
        case (state_q)
            IDLE: begin
                if (spy_grant) begin
                    state_d = spy.spy_we ? ACK : RD_WAIT;
                end
            end
            RD_WAIT: begin
                spy_rdata_d = ram_q;
                state_d     = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            spy_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            spy_rdata_q <= spy_rdata_d;
        end
    end

    assign spy.spy_ack   = (state_q == ACK);
    assign spy.spy_rdata = spy_rdata_q;
endmodule

// File: tb/tb_pdl_arbiter.sv
// Directed bench for pdl_arbiter with a behavioural 1Kx32 synchronous RAM.
// Follows PDL_ARB_STARVE_EN to pick the priority or starvation scenario.
module tb_pdl_arbiter;
    import pdl_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_rd, cpu_wr;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic [9:0]  ram_addr;
    logic [31:0] ram_data;
    logic        ram_rden, ram_wren;
    logic [31:0] ram_q;
    logic [31:0] mem [1024];

    int n_vec = 0;
    int n_bad = 0;

    pdl_arbiter_if #(.ADDR_W(10), .DATA_W(32)) spy_bus ();

    pdl_arbiter #(
        .ADDR_W     (10),
        .DATA_W     (32),
        .STARVE_MAX (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_stall (cpu_stall),
        .cpu_rdata (cpu_rdata),
        .spy       (spy_bus),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_rden  (ram_rden),
        .ram_wren  (ram_wren),
        .ram_q     (ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        if (ram_rden) ram_q <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset             = 1'b1;
        cpu_addr          = '0;
        cpu_wdata         = '0;
        cpu_rd            = 1'b0;
        cpu_wr            = 1'b1;
        spy_bus.spy_req   = 1'b0;
        spy_bus.spy_we    = 1'b0;
        spy_bus.spy_addr  = '0;
        spy_bus.spy_wdata = '0;

        // Reset state with a CPU write pending: enables must stay off.
        repeat (2) next_cycle();
        @(negedge clk);
        chk("rst_stall", 32'(cpu_stall), 32'd1);
        chk("rst_wren", 32'(ram_wren), 32'd0);
        chk("rst_rden", 32'(ram_rden), 32'd0);
        chk("rst_ack", 32'(spy_bus.spy_ack), 32'd0);
        chk("rst_rdata", spy_bus.spy_rdata, 32'd0);

        // CPU only: write 0o17 then read it back.
        next_cycle();
        reset = 1'b0; cpu_wr = 1'b1; cpu_addr = 10'o17; cpu_wdata = 32'o123456;
        @(negedge clk);
        chk("cpu_wr_wren", 32'(ram_wren), 32'd1);
        chk("cpu_wr_stall", 32'(cpu_stall), 32'd0);
        next_cycle();
        cpu_wr = 1'b0; cpu_rd = 1'b1;
        @(negedge clk);
        chk("cpu_rd_rden", 32'(ram_rden), 32'd1);
        chk("cpu_rd_wren", 32'(ram_wren), 32'd0);
        next_cycle();
        cpu_rd = 1'b0;
        @(negedge clk);
        chk("cpu_rdata", cpu_rdata, 32'o123456);
        chk("cpu_only_ack", 32'(spy_bus.spy_ack), 32'd0);

        // Spy write, CPU idle: grant now, ack next cycle.
        next_cycle();
        spy_bus.spy_req = 1'b1; spy_bus.spy_we = 1'b1;
        spy_bus.spy_addr = 10'o1777; spy_bus.spy_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("spy_wr_wren", 32'(ram_wren), 32'd1);
        chk("spy_wr_addr", 32'(ram_addr), 32'o1777);
        chk("spy_wr_data", ram_data, 32'hDEADBEEF);
        chk("spy_wr_ack_g", 32'(spy_bus.spy_ack), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("spy_wr_ack_g1", 32'(spy_bus.spy_ack), 32'd1);
        next_cycle();
        spy_bus.spy_req = 1'b0;
        @(negedge clk);
        chk("spy_wr_ack_drop", 32'(spy_bus.spy_ack), 32'd0);

        // Spy read of the same word: ack two cycles after grant.
        next_cycle();
        spy_bus.spy_req = 1'b1; spy_bus.spy_we = 1'b0;
        @(negedge clk);
        chk("spy_rd_rden", 32'(ram_rden), 32'd1);
        chk("spy_rd_wren", 32'(ram_wren), 32'd0);
        chk("spy_rd_ack_g", 32'(spy_bus.spy_ack), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("spy_rd_ack_g1", 32'(spy_bus.spy_ack), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("spy_rd_ack_g2", 32'(spy_bus.spy_ack), 32'd1);
        chk("spy_rd_data", spy_bus.spy_rdata, 32'hDEADBEEF);

        // Write-over-read at address 5.
        next_cycle();
        spy_bus.spy_req = 1'b0;
        cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 10'd5; cpu_wdata = 32'h5555_0005;
        @(negedge clk);
        chk("wor_wren", 32'(ram_wren), 32'd1);
        chk("wor_rden", 32'(ram_rden), 32'd0);

        // CPU reads address 5 every cycle while the spy asks to read 0o17.
        next_cycle();
        cpu_wr = 1'b0; cpu_rd = 1'b1;
        spy_bus.spy_req = 1'b1; spy_bus.spy_we = 1'b0; spy_bus.spy_addr = 10'o17;
`ifdef PDL_ARB_STARVE_EN
        for (int i = 0; i < 8; i++) begin
            if (i > 0) next_cycle();
            @(negedge clk);
            chk($sformatf("starve_wait%0d_stall", i + 1), 32'(cpu_stall), 32'd0);
            chk($sformatf("starve_wait%0d_addr", i + 1), 32'(ram_addr), 32'd5);
            if (i > 0) chk($sformatf("starve_wait%0d_rdata", i + 1), cpu_rdata, 32'h5555_0005);
        end
        next_cycle();
        @(negedge clk);
        chk("starve_force_stall", 32'(cpu_stall), 32'd1);
        chk("starve_force_addr", 32'(ram_addr), 32'o17);
        chk("starve_force_rden", 32'(ram_rden), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("starve_after_stall", 32'(cpu_stall), 32'd0);
        chk("starve_after_addr", 32'(ram_addr), 32'd5);
        chk("starve_after_rden", 32'(ram_rden), 32'd1);
        chk("starve_after_ack", 32'(spy_bus.spy_ack), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("starve_ack", 32'(spy_bus.spy_ack), 32'd1);
        chk("starve_spy_rdata", spy_bus.spy_rdata, 32'o123456);
        chk("starve_cpu_rdata", cpu_rdata, 32'h5555_0005);
        next_cycle();
        spy_bus.spy_req = 1'b0; cpu_rd = 1'b0;
`else
        for (int i = 0; i < 20; i++) begin
            if (i > 0) next_cycle();
            @(negedge clk);
            chk($sformatf("prio%0d_stall", i), 32'(cpu_stall), 32'd0);
            chk($sformatf("prio%0d_addr", i), 32'(ram_addr), 32'd5);
            chk($sformatf("prio%0d_ack", i), 32'(spy_bus.spy_ack), 32'd0);
            if (i > 0) chk($sformatf("prio%0d_rdata", i), cpu_rdata, 32'h5555_0005);
        end
        next_cycle();
        cpu_rd = 1'b0;
        @(negedge clk);
        chk("prio_grant_addr", 32'(ram_addr), 32'o17);
        chk("prio_grant_rden", 32'(ram_rden), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("prio_ack_g1", 32'(spy_bus.spy_ack), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("prio_ack_g2", 32'(spy_bus.spy_ack), 32'd1);
        chk("prio_spy_rdata", spy_bus.spy_rdata, 32'o123456);
        next_cycle();
        spy_bus.spy_req = 1'b0;
`endif

        // Reset while in RD_WAIT aborts the spy read.
        next_cycle();
        spy_bus.spy_req = 1'b1; spy_bus.spy_we = 1'b0; spy_bus.spy_addr = 10'd5;
        @(negedge clk);
        chk("abort_grant_rden", 32'(ram_rden), 32'd1);
        next_cycle();
        reset = 1'b1; spy_bus.spy_req = 1'b0; cpu_wr = 1'b1; cpu_addr = 10'd9;
        @(negedge clk);
        chk("abort_rst_wren", 32'(ram_wren), 32'd0);
        chk("abort_rst_rden", 32'(ram_rden), 32'd0);
        chk("abort_rst_stall", 32'(cpu_stall), 32'd1);
        chk("abort_rst_ack", 32'(spy_bus.spy_ack), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("abort_rst_ack2", 32'(spy_bus.spy_ack), 32'd0);
        chk("abort_rst_rdata", spy_bus.spy_rdata, 32'd0);
        next_cycle();
        reset = 1'b0; cpu_wr = 1'b0;
        @(negedge clk);
        chk("abort_post_ack", 32'(spy_bus.spy_ack), 32'd0);
        chk("abort_post_stall", 32'(cpu_stall), 32'd0);
        chk("abort_post_rdata", spy_bus.spy_rdata, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("abort_post_ack2", 32'(spy_bus.spy_ack), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
